// File: rtl/jerky_pkg.sv
// jerky_pkg: shared state type and pattern-length helpers
// for the jerky beat sequencer.
package jerky_pkg;

    localparam int IDXW = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DRAIN
    } seq_state_t;

    function automatic int pat_len(int w);
        return 2 * w - 2;
    endfunction

    // Out-of-range requests (0 or beyond the pattern) run the full pattern.
    function automatic logic [IDXW-1:0] eff_steps(
        logic [IDXW-1:0] s,
        int              len
    );
        if (s == '0 || int'(s) > len) begin
            return IDXW'(len);
        end
        return s;
    endfunction

endpackage

// File: rtl/jerky_seq_ctrl_if.sv
// jerky_seq_ctrl_if: control inputs and beat stream outputs
// of the jerky sequencer.
interface jerky_seq_ctrl_if
    import jerky_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic             start;
    logic             stop;
    logic             hold;
    logic             mode;
    logic [IDXW-1:0]  steps;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] count;
    logic [IDXW-1:0]  step_idx;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (
        output start, stop, hold, mode, steps, out_ready,
        input  out_valid, count, step_idx, busy, done, wrap
    );

    modport slave (
        input  start, stop, hold, mode, steps, out_ready,
        output out_valid, count, step_idx, busy, done, wrap
    );

endinterface

// File: rtl/jerky_pattern.sv
// jerky_pattern: maps pattern index k to its beat value,
// 1 on even k and 1<<((k+1)/2) on odd k.
module jerky_pattern
    import jerky_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [IDXW-1:0]  k,
    output logic [WIDTH-1:0] count
);

    logic [IDXW-1:0] sh;

    always_comb begin
        sh    = (k + IDXW'(1)) >> 1;
        count = k[0] ? (WIDTH'(1) << sh) : WIDTH'(1);
    end

endmodule

// File: rtl/jerky_seq_ctrl.sv
// jerky_seq_ctrl: issues the jerky pattern as a valid/ready beat
// stream with one-shot/continuous runs, pause and drain-on-stop.
module jerky_seq_ctrl
    import jerky_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic             clock,
    input logic             reset,
    jerky_seq_ctrl_if.slave bus
);

    localparam int L = pat_len(WIDTH);

    seq_state_t       state_q, state_d;
    logic [IDXW-1:0]  k_q, k_d;
    logic [IDXW-1:0]  steps_q, steps_d;
    logic             mode_q, mode_d;
    logic             wpend_q, wpend_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] pat;
    logic             last;

    jerky_pattern #(.WIDTH(WIDTH)) u_pat (
        .k     (k_d),
        .count (pat)
    );

    assign last = (k_q == steps_q - IDXW'(1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        steps_d = steps_q;
        mode_d  = mode_q;
        wpend_d = wpend_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                k_d     = '0;
                wpend_d = 1'b0;
                if (bus.start && !bus.stop) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    steps_d = eff_steps(bus.steps, L);
                    mode_d  = bus.mode;
                end
            end
            RUN: begin
                valid_d = 1'b1;
                if (bus.out_ready) begin
                    if (bus.stop) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else if (last && mode_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d = last ? '0 : k_q + IDXW'(1);
                        // A wrap taken into PAUSE is reported on resume.
                        if (bus.hold) begin
                            state_d = PAUSE;
                            valid_d = 1'b0;
                            wpend_d = last;
                        end else begin
                            wrap_d = last;
                        end
                    end
                end else if (bus.stop) begin
                    state_d = DRAIN;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (!bus.hold) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    wrap_d  = wpend_q;
                    wpend_d = 1'b0;
                end
            end
            DRAIN: begin
                valid_d = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        idx_d   = valid_d ? k_d : '0;
        count_d = valid_d ? pat : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            steps_q <= IDXW'(L);
            mode_q  <= 1'b0;
            wpend_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            steps_q <= steps_d;
            mode_q  <= mode_d;
            wpend_q <= wpend_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.count     = count_q;
    assign bus.step_idx  = idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_jerky_seq_ctrl.sv
// tb_jerky_seq_ctrl: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_jerky_seq_ctrl;
    import jerky_pkg::*;

    localparam int W = 8;
    localparam int L = 2 * W - 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    jerky_seq_ctrl_if #(.WIDTH(W)) bus ();

    jerky_seq_ctrl #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int st, sp, h, m, s, r;
        int v, c, i, b, d, w;
    } vec_t;

    vec_t tbl [12];

    // reference model state
    int m_act, m_pend, m_drain, m_owe, m_one, m_k, m_n, m_done, m_wrap;

    function automatic int pat(int k);
        return (k % 2 == 0) ? 1 : (1 << ((k + 1) / 2));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_outs(input string tag, input int v, input int c,
                               input int i, input int b, input int d,
                               input int w);
        chk({tag, ".out_valid"}, int'(bus.out_valid), v);
        chk({tag, ".count"}, int'(bus.count), c);
        chk({tag, ".step_idx"}, int'(bus.step_idx), i);
        chk({tag, ".busy"}, int'(bus.busy), b);
        chk({tag, ".done"}, int'(bus.done), d);
        chk({tag, ".wrap"}, int'(bus.wrap), w);
    endtask

    task automatic set_in(input int st, input int sp, input int h,
                          input int m, input int s, input int r);
        bus.start     = st[0];
        bus.stop      = sp[0];
        bus.hold      = h[0];
        bus.mode      = m[0];
        bus.steps     = 4'(s);
        bus.out_ready = r[0];
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #2;
        expect_outs("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    task automatic model_clear();
        m_act = 0; m_pend = 0; m_drain = 0; m_owe = 0;
        m_one = 0; m_k = 0; m_n = L; m_done = 0; m_wrap = 0;
    endtask

    // Tracks one clock edge at the level of "is a run active, is a beat
    // on offer, which pattern index, how many beats make a run".
    task automatic model_edge(input int st, input int sp, input int h,
                              input int m, input int s, input int r);
        int fin;
        m_done = 0;
        m_wrap = 0;
        if (m_act == 0) begin
            if (st != 0 && sp == 0) begin
                m_act = 1; m_pend = 1; m_k = 0; m_drain = 0; m_owe = 0;
                m_n = (s == 0 || s > L) ? L : s;
                m_one = m;
            end
        end else if (m_drain != 0) begin
            if (r != 0) begin
                m_act = 0; m_pend = 0; m_drain = 0;
            end
        end else if (m_pend != 0) begin
            if (r != 0) begin
                fin = (m_k + 1 == m_n) ? 1 : 0;
                if (sp != 0) begin
                    m_act = 0; m_pend = 0;
                end else if (fin != 0 && m_one != 0) begin
                    m_act = 0; m_pend = 0; m_done = 1;
                end else begin
                    m_k = (fin != 0) ? 0 : m_k + 1;
                    if (h != 0) begin
                        m_pend = 0; m_owe = fin;
                    end else begin
                        m_wrap = fin;
                    end
                end
            end else if (sp != 0) begin
                m_drain = 1;
            end
        end else begin
            if (sp != 0) begin
                m_act = 0;
            end else if (h == 0) begin
                m_pend = 1; m_wrap = m_owe; m_owe = 0;
            end
        end
    endtask

    initial begin
        int st, sp, h, m, s, r;

        tbl[0]  = '{1, 0, 0, 1, 3, 1,  1, 1, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 3, 1,  1, 2, 1, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 3, 0,  1, 2, 1, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 3, 1,  0, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 3, 1,  1, 1, 2, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 3, 1,  0, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 1, 3, 1,  0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 1, 3, 1,  0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 2, 1,  1, 1, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 2, 1,  1, 2, 1, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 2, 1,  1, 1, 0, 1, 0, 1};
        tbl[11] = '{0, 1, 0, 0, 2, 1,  0, 0, 0, 0, 0, 0};

        do_reset();
        expect_outs("idle", 0, 0, 0, 0, 0, 0);

        foreach (tbl[n]) begin
            set_in(tbl[n].st, tbl[n].sp, tbl[n].h, tbl[n].m, tbl[n].s, tbl[n].r);
            step();
            expect_outs($sformatf("tbl%0d", n), tbl[n].v, tbl[n].c,
                        tbl[n].i, tbl[n].b, tbl[n].d, tbl[n].w);
        end

        // one-shot, full pattern
        set_in(1, 0, 0, 1, 14, 1);
        step();
        set_in(0, 0, 0, 1, 14, 1);
        for (int k = 0; k < L; k++) begin
            expect_outs("oneshot", 1, pat(k), k, 1, 0, 0);
            step();
        end
        expect_outs("oneshot_done", 0, 0, 0, 0, 1, 0);
        step();
        expect_outs("oneshot_after", 0, 0, 0, 0, 0, 0);

        // continuous, 4 beats
        set_in(1, 0, 0, 0, 4, 1);
        step();
        set_in(0, 0, 0, 0, 4, 1);
        for (int i = 0; i < 10; i++) begin
            expect_outs("loop", 1, pat(i % 4), i % 4, 1, 0,
                        (i > 0 && i % 4 == 0) ? 1 : 0);
            step();
        end
        set_in(0, 1, 0, 0, 4, 1);
        step();
        expect_outs("loop_stop", 0, 0, 0, 0, 0, 0);

        // stall at k=3, stop while pending -> drain
        set_in(1, 0, 0, 1, 14, 1);
        step();
        set_in(0, 0, 0, 1, 14, 1);
        repeat (3) step();
        expect_outs("pre_stall", 1, 4, 3, 1, 0, 0);
        set_in(0, 0, 0, 1, 14, 0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) set_in(0, 1, 0, 1, 14, 0);
            step();
            expect_outs("stall", 1, 4, 3, 1, 0, 0);
        end
        set_in(0, 1, 0, 1, 14, 1);
        step();
        expect_outs("drain_exit", 0, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 1, 14, 1);
        step();
        expect_outs("drain_idle", 0, 0, 0, 0, 0, 0);

        // hold on accept of k=1 for 3 cycles
        set_in(1, 0, 0, 1, 14, 1);
        step();
        set_in(0, 0, 0, 1, 14, 1);
        step();
        expect_outs("pre_hold", 1, 2, 1, 1, 0, 0);
        set_in(0, 0, 1, 1, 14, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold.out_valid", int'(bus.out_valid), 0);
            chk("hold.busy", int'(bus.busy), 1);
        end
        set_in(0, 0, 0, 1, 14, 1);
        step();
        expect_outs("resume", 1, 1, 2, 1, 0, 0);
        set_in(0, 1, 0, 1, 14, 1);
        step();
        expect_outs("resume_stop", 0, 0, 0, 0, 0, 0);

        // asynchronous reset at k=6
        set_in(1, 0, 0, 1, 14, 1);
        step();
        set_in(0, 0, 0, 1, 14, 1);
        repeat (6) step();
        expect_outs("pre_reset", 1, 1, 6, 1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        expect_outs("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        step();
        expect_outs("post_reset", 0, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 1, 14, 1);
        step();
        expect_outs("restart", 1, 1, 0, 1, 0, 0);
        set_in(0, 1, 0, 1, 14, 1);
        step();
        expect_outs("restart_stop", 0, 0, 0, 0, 0, 0);

        // steps=0 means a full run
        set_in(1, 0, 0, 1, 0, 1);
        step();
        set_in(0, 0, 0, 1, 0, 1);
        for (int k = 0; k < L; k++) begin
            expect_outs("steps0", 1, pat(k), k, 1, 0, 0);
            step();
        end
        expect_outs("steps0_done", 0, 0, 0, 0, 1, 0);
        set_in(1, 1, 0, 0, 5, 1);
        step();
        expect_outs("start_stop", 0, 0, 0, 0, 0, 0);

        // randomized traffic vs model
        do_reset();
        model_clear();
        for (int c = 0; c < 800; c++) begin
            st = ($urandom_range(0, 3) == 0) ? 1 : 0;
            sp = ($urandom_range(0, 19) == 0) ? 1 : 0;
            h  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            m  = int'($urandom_range(0, 1));
            s  = int'($urandom_range(0, 15));
            r  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            set_in(st, sp, h, m, s, r);
            model_edge(st, sp, h, m, s, r);
            step();
            expect_outs($sformatf("rand%0d", c), m_pend,
                        (m_pend != 0) ? pat(m_k) : 0,
                        (m_pend != 0) ? m_k : 0,
                        m_act, m_done, m_wrap);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jerky_seq_ctrl.md
JERKY_SEQ_CTRL -- requirements
Module: jerky_seq_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, count width; pattern length L = 2*WIDTH-2 (14 at default).
REQ-002 SHALL have port: clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  in  1  begin a run; sampled only in IDLE.
REQ-005 SHALL have port: stop  in  1  abort the current run.
REQ-006 SHALL have port: hold  in  1  pause beat issue while high.
REQ-007 SHALL have port: mode  in  1  0 = continuous loop, 1 = one-shot.
REQ-008 SHALL have port: steps  in  4  beats per run, 1..L; 0 or >L treated as L; latched at start.
REQ-009 SHALL have port: out_ready  in  1  downstream accepts the current beat.
REQ-010 SHALL have port: out_valid  out  1  count holds a valid beat.
REQ-011 SHALL have port: count  out  WIDTH  pattern value of the current beat.
REQ-012 SHALL have port: step_idx  out  4  pattern index k of the current beat, 0..L-1.
REQ-013 SHALL have port: busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port: done  out  1  one-cycle pulse when a one-shot run completes.
REQ-015 SHALL have port: wrap  out  1  one-cycle pulse when a continuous run restarts at k=0.

Function
REQ-016 Pattern SHALL be count = 1 for even k and count = 1<<((k+1)/2) for odd k (1,2,1,4,...,1,128).
REQ-017 FSM states SHALL be IDLE, RUN, PAUSE and DRAIN.
REQ-018 All outputs SHALL be registered.
REQ-019 In IDLE, count, step_idx and out_valid SHALL be 0.
REQ-020 Accept: a beat SHALL be accepted on a rising edge where out_valid=1 and out_ready=1.
REQ-021 Once asserted, out_valid, count and step_idx SHALL stay stable until the beat is accepted or reset asserts.
REQ-022 IDLE->RUN: when start=1 and stop=0 in cycle N, out_valid=1, k=0, count=1 SHALL appear in cycle N+1.
REQ-023 In RUN, on accept with hold=0, the next beat SHALL be presented in the following cycle (no bubble).
REQ-024 One-shot: after accepting beat number steps, the FSM SHALL enter IDLE with out_valid=0 and pulse done for one cycle.
REQ-025 Continuous: after accepting beat number steps, the FSM SHALL restart at k=0 in the next cycle and pulse wrap for one cycle.
REQ-026 RUN->PAUSE: when hold=1 on an accepting edge, the FSM SHALL enter PAUSE with out_valid=0; a pending beat SHALL never be withdrawn.
REQ-027 PAUSE->RUN: when hold=0, the FSM SHALL present the next beat one cycle later.
REQ-028 stop in RUN or PAUSE with no unaccepted beat SHALL return the FSM to IDLE next cycle with no done pulse.
REQ-029 stop while a beat is pending but not accepted SHALL move the FSM to DRAIN, which holds the beat until it is accepted and then enters IDLE.
REQ-030 stop SHALL take priority over hold, and over start in IDLE.
REQ-031 start while busy=1 SHALL be ignored.

Reset
REQ-032 reset=0 SHALL force IDLE immediately, independent of clock.
REQ-033 During reset, count, step_idx, out_valid, busy, done and wrap SHALL all be 0, and the latched steps value SHALL be L.
REQ-034 Reset asserted mid-run SHALL discard the pending beat; the first start after release SHALL begin at k=0.

Structure
REQ-035 A shared package jerky_pkg SHALL hold the FSM state enum (seq_state_t) and the function or constant giving the pattern length.
REQ-036 The pattern SHALL be generated by one sub-module, jerky_pattern: combinational mapping of k to count, parameterised by WIDTH.
REQ-037 jerky_seq_ctrl SHALL own the FSM, the index and beat counters, and the output registers.

Verification
REQ-038 Bench SHALL cover: mode=1, steps=14, out_ready=1, start pulse -> counts 1,2,1,4,1,8,1,16,1,32,1,64,1,128 on consecutive cycles, then done pulse and busy=0.
REQ-039 Bench SHALL cover: mode=0, steps=4, out_ready=1 -> counts 1,2,1,4 repeating, with wrap=1 in the cycle that presents k=0 again.
REQ-040 Bench SHALL cover: out_ready=0 for 5 cycles at k=3 -> count=4 and out_valid held stable for those 5 cycles; stop asserted meanwhile -> DRAIN, then IDLE after accept, no done pulse.
REQ-041 Bench SHALL cover: hold=1 on accept of k=1 for 3 cycles -> out_valid=0 for 3 cycles, then count=1 at k=2.
REQ-042 Bench SHALL cover: reset=0 asserted between edges at k=6 -> all outputs 0 immediately; after release, start -> count=1 at k=0.
REQ-043 Bench SHALL cover: steps=0 -> 14 beats run; start and stop in the same cycle in IDLE -> stays IDLE.
